inner_unshuffle: RTL and testbench

//  Streaming inverse-transpose with SIMD parallelism; sits downstream of inner_shuffle.
//  - Input: column-major (J,I) words. Each word holds SIMD consecutive i at fixed j.
//  - Output: row-major (I,J) words. Each word holds SIMD consecutive j at fixed i.
//  - Mirror of the banked scheme: permuted scatter on the write side, linear read.
//  - Double-buffered (two pages), so frame n+1 can be written while frame n is read, at II=1.

---
 rtl/inner_unshuffle.sv | 241 ++++++++++++++++++++++++
 tb/tb_inner_unshuffle.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inner_unshuffle.sv
// inner_unshuffle: streaming inverse transpose with SIMD lanes.
// Column-major (J,I) input words are scattered into SIMD rotated banks and
// read back linearly as row-major (I,J) words. Two pages let one frame be
// written while the previous one is read.
// Optional feature: define INNER_UNSHUFFLE_LAST_EN to add the olast output.

// Two-entry skid buffer: registered outputs, registered ready upstream.
module inner_unshuffle_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  logic         buf_vld;
  logic [W-1:0] buf_dat;

  assign in_rdy = !buf_vld;

  // occupancy of the output register and the overflow buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld <= 1'b0;
      buf_vld <= 1'b0;
    end else if (!out_vld || out_rdy) begin
      out_vld <= buf_vld || in_vld;
      buf_vld <= 1'b0;
    end else if (in_vld && !buf_vld) begin
      buf_vld <= 1'b1;
    end
  end

  // output word: buffered word drains first, otherwise take the incoming word
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_dat <= '0;
    end else if (!out_vld || out_rdy) begin
      if (buf_vld)     out_dat <= buf_dat;
      else if (in_vld) out_dat <= in_dat;
    end
  end

  // overflow buffer catches the word in flight when the output stalls
  always_ff @(posedge clk) begin
    if (in_vld && !buf_vld && out_vld && !out_rdy) buf_dat <= in_dat;
  end
endmodule

module inner_unshuffle #(
  parameter int BITS = 8,
  parameter int I    = 4,
  parameter int J    = 8,
  parameter int SIMD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 irdy,
  input  logic                 ivld,
  input  logic [SIMD*BITS-1:0] idat,
  input  logic                 ordy,
  output logic                 ovld,
`ifdef INNER_UNSHUFFLE_LAST_EN
  output logic                 olast,
`endif
  output logic [SIMD*BITS-1:0] odat
);
  localparam int JB    = J / SIMD;
  localparam int IB    = I / SIMD;
  localparam int P     = I * J / SIMD;
  localparam int DEPTH = 2 * P;
  localparam int AW    = $clog2(DEPTH);
  localparam int JW    = $clog2(J);
  localparam int IW    = $clog2(I);
  localparam int JBW   = (JB > 1) ? $clog2(JB) : 1;
  localparam int IBW   = (IB > 1) ? $clog2(IB) : 1;
  localparam int SW    = $clog2(SIMD);

  if (I % SIMD != 0) begin : g_bad_i
    $fatal(1, "inner_unshuffle: I must be a multiple of SIMD");
  end
  if (J % SIMD != 0) begin : g_bad_j
    $fatal(1, "inner_unshuffle: J must be a multiple of SIMD");
  end
  if (SIMD < 2 || (SIMD & (SIMD - 1)) != 0) begin : g_bad_simd
    $fatal(1, "inner_unshuffle: SIMD must be a power of two >= 2");
  end

  logic [JW-1:0]  wr_j;
  logic [IBW-1:0] wr_ib;
  logic           wr_page;
  logic [IW-1:0]  rd_i;
  logic [JBW-1:0] rd_jb;
  logic           rd_page;
  logic [1:0]     full;
  logic [1:0]     full_nxt;
  logic           wr_fire, wr_last, wr_page_nxt;
  logic           vld_p0, rd_adv, rd_last, skid_rdy;
  logic [AW-1:0]  wr_addr [SIMD];
  logic [BITS-1:0] wr_dat [SIMD];
  logic [AW-1:0]  rd_addr_p0;
  logic [BITS-1:0] bank_q_p1 [SIMD];
  logic           vld_p1;
  logic [SW-1:0]  rot_p1;
  logic [SIMD*BITS-1:0] dat_p1;

  assign wr_fire     = ivld && irdy;
  assign wr_last     = wr_fire && (wr_j == JW'(J - 1)) && (wr_ib == IBW'(IB - 1));
  assign vld_p0      = full[rd_page];
  assign rd_adv      = vld_p0 && skid_rdy;
  assign rd_last     = rd_adv && (rd_i == IW'(I - 1)) && (rd_jb == JBW'(JB - 1));
  assign wr_page_nxt = wr_page ^ wr_last;
  assign rd_addr_p0  = AW'(int'(rd_page) * P + int'(rd_i) * JB + int'(rd_jb));

  // page flags: a finished write sets its page, a finished read clears its page
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_page] = 1'b1;
    if (rd_last) full_nxt[rd_page] = 1'b0;
  end

  // write scatter: bank b takes the lane whose element rotates onto it
  always_comb begin
    int lane;
    lane = 0;
    for (int b = 0; b < SIMD; b++) begin
      lane       = (b + SIMD - int'(wr_j) % SIMD) % SIMD;
      wr_addr[b] = AW'(int'(wr_page) * P + (int'(wr_ib) * SIMD + lane) * JB + int'(wr_j) / SIMD);
      wr_dat[b]  = idat[lane*BITS +: BITS];
    end
  end

  // write/read counters, page pointers, flags and the registered input ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_j    <= '0;
      wr_ib   <= '0;
      wr_page <= 1'b0;
      rd_i    <= '0;
      rd_jb   <= '0;
      rd_page <= 1'b0;
      full    <= '0;
      irdy    <= 1'b0;
    end else begin
      full    <= full_nxt;
      wr_page <= wr_page_nxt;
      rd_page <= rd_page ^ rd_last;
      irdy    <= !full_nxt[wr_page_nxt];
      if (wr_fire) begin
        if (wr_ib == IBW'(IB - 1)) begin
          wr_ib <= '0;
          wr_j  <= (wr_j == JW'(J - 1)) ? '0 : wr_j + 1'b1;
        end else begin
          wr_ib <= wr_ib + 1'b1;
        end
      end
      if (rd_adv) begin
        if (rd_jb == JBW'(JB - 1)) begin
          rd_jb <= '0;
          rd_i  <= (rd_i == IW'(I - 1)) ? '0 : rd_i + 1'b1;
        end else begin
          rd_jb <= rd_jb + 1'b1;
        end
      end
    end
  end

  // ---- p0 -> p1: bank read, held while the skid cannot accept ----
  for (genvar b = 0; b < SIMD; b++) begin : g_bank
    logic [BITS-1:0] mem [DEPTH];
    logic [BITS-1:0] q_p1;
    // one lane written per bank per beat; read register holds on backpressure
    always_ff @(posedge clk) begin
      if (wr_fire)  mem[wr_addr[b]] <= wr_dat[b];
      if (skid_rdy) q_p1 <= mem[rd_addr_p0];
    end
    assign bank_q_p1[b] = q_p1;
  end

  // valid travelling with the bank read
  always_ff @(posedge clk) begin
    if (!rst)          vld_p1 <= 1'b0;
    else if (skid_rdy) vld_p1 <= vld_p0;
  end

`ifdef INNER_UNSHUFFLE_LAST_EN
  logic last_p1;
  // rotation and end-of-frame tag captured with the bank read
  always_ff @(posedge clk) begin
    if (skid_rdy) begin
      rot_p1  <= rd_i[SW-1:0];
      last_p1 <= (rd_i == IW'(I - 1)) && (rd_jb == JBW'(JB - 1));
    end
  end
`else
  // rotation captured with the bank read
  always_ff @(posedge clk) begin
    if (skid_rdy) rot_p1 <= rd_i[SW-1:0];
  end
`endif

  // undo the bank rotation: output lane k comes from bank (r+k)%SIMD
  always_comb begin
    dat_p1 = '0;
    for (int k = 0; k < SIMD; k++) begin
      dat_p1[k*BITS +: BITS] = bank_q_p1[(int'(rot_p1) + k) % SIMD];
    end
  end

  // ---- p1 -> p2: skid registers drive the outputs ----
`ifdef INNER_UNSHUFFLE_LAST_EN
  logic [SIMD*BITS:0] sk_out;
  inner_unshuffle_skid #(.W(SIMD*BITS + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (vld_p1),
    .in_rdy  (skid_rdy),
    .in_dat  ({last_p1, dat_p1}),
    .out_vld (ovld),
    .out_rdy (ordy),
    .out_dat (sk_out)
  );
  assign olast = sk_out[SIMD*BITS];
  assign odat  = sk_out[SIMD*BITS-1:0];
`else
  inner_unshuffle_skid #(.W(SIMD*BITS)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (vld_p1),
    .in_rdy  (skid_rdy),
    .in_dat  (dat_p1),
    .out_vld (ovld),
    .out_rdy (ordy),
    .out_dat (odat)
  );
`endif
endmodule

// File: tb/tb_inner_unshuffle.sv
// Scoreboard bench for inner_unshuffle: frames of (i,j) elements are driven in
// column-major order; the expected row-major words are queued per completed
// frame and a monitor compares every output handshake.
module tb_inner_unshuffle;
  localparam int BITS = 8;
  localparam int I    = 4;
  localparam int J    = 8;
  localparam int SIMD = 2;
  localparam int W    = SIMD * BITS;
  localparam int P    = I * J / SIMD;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         ivld = 1'b0;
  logic         ordy = 1'b0;
  logic [W-1:0] idat = '0;
  logic         irdy, ovld;
  logic [W-1:0] odat;
`ifdef INNER_UNSHUFFLE_LAST_EN
  logic         olast;
  int           olast_cnt = 0;
`endif

  inner_unshuffle #(.BITS(BITS), .I(I), .J(J), .SIMD(SIMD)) dut (
    .clk  (clk),
    .rst  (rst),
    .irdy (irdy),
    .ivld (ivld),
    .idat (idat),
    .ordy (ordy),
    .ovld (ovld),
`ifdef INNER_UNSHUFFLE_LAST_EN
    .olast(olast),
`endif
    .odat (odat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [W-1:0] exp_q[$];
  bit           last_q[$];
  int ordy_mode = 0;            // 0 high, 1 random, 2 low
  int out_cnt = 0, pushed_cnt = 0;
  int first_out_cyc = -1, last_out_cyc = -1, last_hs_cyc = 0;
  int stalls = 0, fid = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_dat = '0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [BITS-1:0] val(input int i, input int j, input int f);
    return BITS'((i * J + j + 32 * f) % 256);
  endfunction

  // reference model: row-major words of the restored matrix
  task automatic push_frame(input int f);
    logic [W-1:0] w;
    for (int i = 0; i < I; i++)
      for (int jb = 0; jb < J / SIMD; jb++) begin
        for (int k = 0; k < SIMD; k++) w[k*BITS +: BITS] = val(i, jb * SIMD + k, f);
        exp_q.push_back(w);
        last_q.push_back(i == I - 1 && jb == J / SIMD - 1);
        pushed_cnt++;
      end
  endtask

  task automatic wait_hs();
    int t = 0;
    @(negedge clk);
    while (!irdy && t < 300) begin @(negedge clk); t++; end
    stalls += t;
    if (!irdy) begin
      checks++; errors++;
      $display("FAIL irdy_timeout: irdy stuck at 0 for %0d cycles", t);
    end
    last_hs_cyc = cyc;
    @(posedge clk); #1;
    ivld = 1'b0;
  endtask

  // drive nbeats of a frame (all P beats completes it); gap_pct = idle chance
  task automatic send_frame(input int nbeats, input int gap_pct);
    int b = 0;
    for (int j = 0; j < J; j++)
      for (int ib = 0; ib < I / SIMD; ib++)
        if (b < nbeats) begin
          while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            ivld = 1'b0; @(posedge clk); #1;
          end
          ivld = 1'b1;
          for (int k = 0; k < SIMD; k++) idat[k*BITS +: BITS] = val(ib * SIMD + k, j, fid);
          wait_hs();
          b++;
        end
    if (b == P) push_frame(fid);
    fid++;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check("drain_empty", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // output ready pattern
  initial forever begin
    @(posedge clk); #1;
    case (ordy_mode)
      0:       ordy = 1'b1;
      1:       ordy = 1'($urandom_range(0, 1));
      default: ordy = 1'b0;
    endcase
  end

  // monitor: stability under backpressure and in-order comparison
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_ovld", ovld, 1);
        check("hold_odat", odat, prev_dat);
      end
      if (ovld && first_out_cyc < 0) first_out_cyc = cyc;
      if (ovld && ordy) begin
        out_cnt++;
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %h with no word expected", odat);
        end else begin
          logic [W-1:0] e;
          bit l;
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("odat", odat, e);
`ifdef INNER_UNSHUFFLE_LAST_EN
          check("olast", olast, l);
          if (olast) olast_cnt++;
`else
          if (l) prev_dat = odat;
`endif
        end
      end
      prev_stall = ovld && !ordy;
      prev_dat   = odat;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n, t;
    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irdy", irdy, 0);
    check("rst_ovld", ovld, 0);
    check("rst_odat", odat, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("irdy_after_rst", irdy, 1);

    // 1: one frame, latency
    ordy_mode = 0; ordy = 1'b1;
    first_out_cyc = -1;
    send_frame(P, 0);
    drain();
    check("latency", first_out_cyc - last_hs_cyc, 3);

    // 2: three back-to-back frames
    stalls = 0; first_out_cyc = -1;
    for (int f = 0; f < 3; f++) send_frame(P, 0);
    drain();
    check("b2b_irdy_stalls", stalls, 0);
    check("b2b_out_span", last_out_cyc - first_out_cyc, 3 * P - 1);

    // 3: random ordy and ivld gaps
    ordy_mode = 1;
    for (int f = 0; f < 4; f++) send_frame(P, 30);
    drain();

    // 4: output blocked while two frames are written
    ordy_mode = 2; ordy = 1'b0;
    send_frame(P, 0);
    send_frame(P, 0);
    hi = 0;
    repeat (6) begin @(negedge clk); if (irdy) hi++; end
    check("irdy_low_both_full", hi, 0);
    ordy_mode = 0; ordy = 1'b1;
    n = 0; t = 0;
    while (n < P && t < 500) begin
      @(negedge clk); t++;
      if (ovld && ordy) n++;
    end
    check("drain_handshakes", n, P);
    @(negedge clk);
    check("irdy_return", irdy, 1);
    drain();

    // 5: reset mid-frame discards the partial frame
    send_frame(5, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_irdy", irdy, 0);
    check("midrst_ovld", ovld, 0);
    check("midrst_odat", odat, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_irdy_release", irdy, 1);
    send_frame(P, 0);
    drain();

`ifdef INNER_UNSHUFFLE_LAST_EN
    // 6: end-of-frame marker
    olast_cnt = 0;
    send_frame(P, 0);
    send_frame(P, 0);
    drain();
    check("olast_count", olast_cnt, 2);
`endif

    check("out_total", out_cnt, pushed_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
